// File: rtl/dac_stream_tx.sv
// dac_stream_tx: one DAC channel. Signed samples arrive over a valid/ready
// handshake and are buffered in a small FIFO. They are played out at a
// programmable rate as offset-binary words, together with a latch clock whose
// rising edge sits inside each sample period.
//
// state | meaning
// IDLE  | stopped; FIFO flushed, DAC held at mid-scale, latch clock low
// PRIME | accepting samples; waiting for the FIFO to reach half full
// RUN   | playing out one sample per period; underflows counted when empty
module dac_stream_tx #(
    parameter int DATA_W     = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              rate_div,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_W-1:0]             dac_data,
    output logic                          dac_clk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underflow_cnt,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [LW-1:0]     HALF_LVL  = LW'(FIFO_DEPTH / 2);
    localparam logic [LW-1:0]     FULL_LVL  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  p_div, p_div_next;
    logic [DIV_W-1:0]  cnt, cnt_next;
    logic [DIV_W-1:0]  half_per;
    logic              dac_clk_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_calc;
    logic [DATA_W-1:0] head;
    logic              push, pop, tick, fifo_empty, underflow_evt;

    // Handshake and FIFO status come from registered state only.
    assign s_ready       = (state != IDLE) && (fifo_level != FULL_LVL);
    assign busy          = (state != IDLE);
    assign fifo_empty    = (fifo_level == '0);
    assign push          = s_valid && s_ready;
    assign tick          = (state == RUN) && enable && (cnt == p_div);
    assign pop           = tick && !fifo_empty;
    assign underflow_evt = tick && fifo_empty;
    assign level_calc    = fifo_level + LW'(push) - LW'(pop);
    assign head          = mem[rd_ptr];

    // The latch clock goes high halfway through the period (rounded down), so
    // the word changing at cnt==0 gets H cycles of setup before the rising edge.
    assign half_per = DIV_W'(({1'b0, p_div} + 1'b1) >> 1);

    // Next state, latched period and period counter.
    always_comb begin
        state_next   = state;
        p_div_next   = p_div;
        cnt_next     = '0;
        dac_clk_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_next = PRIME;
            end
            PRIME: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (level_calc >= HALF_LVL) begin
                    state_next = RUN;
                    p_div_next = (rate_div == '0) ? DIV_W'(1) : rate_div;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    cnt_next     = tick ? '0 : cnt + 1'b1;
                    dac_clk_next = (cnt_next >= half_per);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, period and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            p_div <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            p_div <= p_div_next;
            cnt   <= cnt_next;
        end
    end

    // FIFO storage; stale words are harmless because the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // FIFO pointers and occupancy; leaving for IDLE discards the contents.
    always_ff @(posedge clk) begin
        if (reset || (state_next == IDLE)) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_calc;
        end
    end

    // DAC word, latch clock and underflow counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            dac_data      <= MID;
            dac_clk       <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            dac_clk <= dac_clk_next;
            if (state_next == IDLE) begin
                dac_data <= MID;
            end else if (pop) begin
                dac_data <= {~head[DATA_W-1], head[DATA_W-2:0]};
            end
            if (underflow_evt && (underflow_cnt != 16'hFFFF)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end

endmodule
